// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle = 2'd0;
  localparam fetch_state_t StReq  = 2'd1;
  localparam fetch_state_t StWait = 2'd2;
  localparam fetch_state_t StDrop = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/pair_fifo.sv
// Instruction FIFO: one-entry push, two-entry pop, exposes the two oldest entries.
module pair_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fifo_entry_t              push_entry_i,
  input  logic                     pop2_i,
  output fifo_entry_t              head0_o,
  output logic [31:0]              head1_insn_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  fifo_entry_t     mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_nxt;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop2_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(2);
      end
      count_d = count_q + CntW'(push_i) - (pop2_i ? CntW'(2) : CntW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign rd_ptr_nxt   = rd_ptr_q + PtrW'(1);
  assign head0_o      = mem_q[rd_ptr_q];
  assign head1_insn_o = mem_q[rd_ptr_nxt].insn;
  assign count_o      = count_q;

  push_not_full_a: assert property (@(posedge clk) disable iff (rst)
    (push_i && !clear_i) |-> (count_q < FullCnt));

  pop_has_pair_a: assert property (@(posedge clk) disable iff (rst)
    (pop2_i && !clear_i) |-> (count_q >= CntW'(2)));

endmodule

// File: rtl/fetch_pair_buffer.sv
// Fetch front end: one-outstanding memory fetch FSM feeding a pair-issue FIFO.
module fetch_pair_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned Depth   = 8,
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter logic [31:0] NopWord = NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [31:0]            flush_pc_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [31:0]            imem_rdata_i,
  input  logic                   freeze1_i,
  input  logic                   freeze2_i,
  output logic [31:0]            instruction0_o,
  output logic [31:0]            instruction1_o,
  output logic [31:0]            pc0_o,
  output logic                   nothing_filled_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  fetch_state_t    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            push, pop2, nothing_filled;
  fifo_entry_t     push_entry, head0;
  logic [31:0]     head1_insn;
  logic [CntW-1:0] count, count_after;

  assign nothing_filled = (count < CntW'(2));
  assign pop2           = !freeze1_i && !freeze2_i && !nothing_filled && !flush_i;
  assign push           = (state_q == StWait) && imem_rvalid_i && !flush_i;
  assign count_after    = count + CntW'(push) - (pop2 ? CntW'(2) : CntW'(0));

  // In WAIT, fetch_pc already moved past the granted word.
  assign push_entry = '{insn: imem_rdata_i, pc: fetch_pc_q - 32'd4};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i || (count < FullCnt)) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem_gnt_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          // A grant coinciding with a flush leaves a stale response in flight.
          state_d    = flush_i ? StDrop : StWait;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          state_d = (flush_i || (count_after < FullCnt)) ? StReq : StIdle;
        end else if (flush_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid_i) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPc;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  pair_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (flush_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop2_i       (pop2),
    .head0_o      (head0),
    .head1_insn_o (head1_insn),
    .count_o      (count)
  );

  assign imem_req_o       = (state_q == StReq);
  assign imem_addr_o      = fetch_pc_q;
  assign instruction0_o   = (count != '0) ? head0.insn : NopWord;
  assign instruction1_o   = nothing_filled ? NopWord : head1_insn;
  assign pc0_o            = (count != '0) ? head0.pc : fetch_pc_q;
  assign nothing_filled_o = nothing_filled;
  assign count_o          = count;

  addr_stable_a: assert property (@(posedge clk) disable iff (rst)
    (imem_req_o && !imem_gnt_i && !flush_i) |=> (imem_req_o && $stable(imem_addr_o)));

  no_req_when_full_a: assert property (@(posedge clk) disable iff (rst)
    imem_req_o |-> (count < FullCnt));

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Scoreboard bench for fetch_pair_buffer with a randomised memory and scheduler.
module tb_fetch_pair_buffer;

  localparam int unsigned Depth   = 8;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] NopWord = 32'h0000_0013;

  logic        clk, rst, flush;
  logic [31:0] flush_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        freeze1, freeze2;
  logic [31:0] instruction0, instruction1, pc0;
  logic        nothing_filled;
  logic [3:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  int total = 0;
  int bad   = 0;

  int gnt_pct, lat_min, lat_max;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;

  exp_t        exp_q[$];
  logic [31:0] exp_fetch, pend_addr, hold_addr;
  logic        pend_live, hold_chk;

  fetch_pair_buffer #(
    .Depth   (Depth),
    .ResetPc (ResetPc),
    .NopWord (NopWord)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .flush_pc_i       (flush_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .freeze1_i        (freeze1),
    .freeze2_i        (freeze2),
    .instruction0_o   (instruction0),
    .instruction1_o   (instruction1),
    .pc0_o            (pc0),
    .nothing_filled_o (nothing_filled),
    .count_o          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(count) == target) begin
        hit = 1;
        break;
      end
    end
    if (!hit) timeout(name);
  endtask

  task automatic wait_pend(input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pend_live) begin
        hit = 1;
        break;
      end
    end
    if (!hit) timeout(name);
  endtask

  // Memory: one request in flight, random grant, latency in [lat_min, lat_max] cycles.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(mem_addr);
        mem_pend    = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    imem_gnt = 1'b0;
    if (imem_req && !mem_pend && (int'($urandom_range(99)) < gnt_pct)) begin
      imem_gnt = 1'b1;
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_wait = int'($urandom_range(32'(lat_max - 1), 32'(lat_min - 1)));
    end
  end

  // Monitor: samples just before each rising edge, checks, then applies that edge's effects.
  always @(negedge clk) begin
    int sz;
    #3;
    if (rst) begin
      exp_q.delete();
      exp_fetch = ResetPc;
      pend_live = 1'b0;
      hold_chk  = 1'b0;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_nothing_filled", 32'(nothing_filled), 32'd1);
      chk("rst_insn0", instruction0, NopWord);
      chk("rst_insn1", instruction1, NopWord);
      chk("rst_pc0", pc0, ResetPc);
    end else begin
      sz = exp_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("nothing_filled", 32'(nothing_filled), (sz < 2) ? 32'd1 : 32'd0);
      chk("insn0", instruction0, (sz >= 1) ? exp_q[0].word : NopWord);
      chk("insn1", instruction1, (sz >= 2) ? exp_q[1].word : NopWord);
      chk("pc0", pc0, (sz >= 1) ? exp_q[0].pc : exp_fetch);
      if (sz >= int'(Depth)) chk("req_when_full", 32'(imem_req), 32'd0);
      if (hold_chk) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", imem_addr, hold_addr);
      end
      hold_chk  = imem_req && !imem_gnt && !flush;
      hold_addr = imem_addr;

      if (imem_rvalid && pend_live && !flush) begin
        exp_q.push_back('{pc: pend_addr, word: memf(pend_addr)});
        pend_live = 1'b0;
      end
      if (!freeze1 && !freeze2 && (sz >= 2) && !flush) begin
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (imem_req && imem_gnt) begin
        chk("grant_addr", imem_addr, exp_fetch);
        pend_live = !flush;
        pend_addr = imem_addr;
        exp_fetch = exp_fetch + 32'd4;
      end
      if (flush) begin
        exp_q.delete();
        exp_fetch = flush_pc;
        pend_live = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; freeze1 = 1'b1; freeze2 = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; mem_pend = 1'b0; mem_wait = 0;
    mem_addr = '0; exp_fetch = ResetPc; pend_live = 1'b0; pend_addr = '0;
    hold_chk = 1'b0; hold_addr = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fill to four with the scheduler frozen, retire one pair, then hold freeze2.
    wait_count(4, 50, "fill_to_4");
    freeze1 = 1'b0; freeze2 = 1'b0;
    @(negedge clk);
    freeze2 = 1'b1;
    repeat (3) @(negedge clk);

    // Fill completely, stay full, then three pops to wrap the pointers.
    wait_count(int'(Depth), 100, "fill_to_full");
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      freeze2 = 1'b0;
      @(negedge clk);
      freeze2 = 1'b1;
      @(negedge clk);
    end

    // Flush while a fetch is outstanding.
    freeze1 = 1'b0; freeze2 = 1'b0;
    lat_min = 3; lat_max = 3;
    wait_pend(60, "pend_before_flush");
    flush = 1'b1; flush_pc = 32'h0000_0100;
    @(negedge clk);
    flush = 1'b0;
    repeat (30) @(negedge clk);

    // Randomised traffic: grant rate, latency, freezes, flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) begin
        gnt_pct = 30 + int'($urandom_range(70));
        lat_min = 1;
        lat_max = 1 + int'($urandom_range(3));
      end
      freeze1  = ($urandom_range(99) < 25);
      freeze2  = ($urandom_range(99) < 25);
      flush    = ($urandom_range(99) < 3);
      flush_pc = $urandom & 32'hFFFF_FFFC;
      rst      = ($urandom_range(999) < 3);
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; freeze1 = 1'b0; freeze2 = 1'b0;
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    repeat (10) @(negedge clk);

    // Reset during WAIT; the stale response must be ignored.
    wait_pend(60, "pend_before_reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lat_min = 1; lat_max = 2;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
